// File: rtl/sdram_test_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_test_pkg : shared encodings and pattern function for the SDRAM tester
// Revision       : 1.0
// ---------------------------------------------------------------------------
package sdram_test_pkg;

  typedef enum logic [1:0] {
    PAT_INC  = 2'd0,
    PAT_INV  = 2'd1,
    PAT_WALK = 2'd2,
    PAT_CHK  = 2'd3
  } pat_mode_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int PAT_MAX_W = 64;

  // Produced at the widest supported word; callers truncate to DATA_W.
  function automatic logic [PAT_MAX_W-1:0] pat_gen(
    input logic [31:0] idx,
    input pat_mode_e   mode,
    input logic [31:0] width
  );
    logic [PAT_MAX_W-1:0] w_inc;
    w_inc   = {32'd0, idx};
    pat_gen = w_inc;
    case (mode)
      PAT_INC:  pat_gen = w_inc;
      PAT_INV:  pat_gen = ~w_inc;
      PAT_WALK: pat_gen = 64'd1 << ((idx - 32'd1) % width);
      PAT_CHK:  pat_gen = idx[0] ? {32{2'b10}} : {32{2'b01}};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_pattern_gen : write-side pattern plus read-latency valid/index delay
// Revision          : 1.0
// ---------------------------------------------------------------------------
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] wr_pat,
  output logic              chk_vld,
  output logic [ADDR_W-1:0] chk_idx,
  output logic [DATA_W-1:0] chk_pat
);

  logic [RD_LAT-1:0] r_vld_sr;
  logic [ADDR_W-1:0] r_idx_sr [RD_LAT];

  always_ff @(posedge clk_50m) begin
    if (!rst_n || flush) begin
      r_vld_sr <= '0;
      for (int k = 0; k < RD_LAT; k++) r_idx_sr[k] <= '0;
    end else begin
      r_vld_sr[0] <= rd_vld;
      r_idx_sr[0] <= rd_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld_sr[k] <= r_vld_sr[k-1];
        r_idx_sr[k] <= r_idx_sr[k-1];
      end
    end
  end

  assign chk_vld = r_vld_sr[RD_LAT-1];
  assign chk_idx = r_idx_sr[RD_LAT-1];
  assign wr_pat  = DATA_W'(pat_gen(32'(wr_idx), pat_mode_e'(mode), 32'(DATA_W)));
  assign chk_pat = DATA_W'(pat_gen(32'(chk_idx), pat_mode_e'(mode), 32'(DATA_W)));

endmodule
`default_nettype wire

// File: rtl/sdram_pattern_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_pattern_tester : multi-pattern SDRAM write/read-back self-test
// Revision             : 1.0
// ---------------------------------------------------------------------------
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DATA_LENG = 2048,
  parameter int RD_LAT    = 2,
  parameter int CNT_W     = 16,
  localparam int ADDR_W   = $clog2(DATA_LENG + 1)
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        loops,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              error_flag,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(DATA_LENG);
  localparam logic [LAT_W-1:0]  C_LAT_END = LAT_W'(RD_LAT);

  logic              r_init_meta, r_init_s;
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [LAT_W-1:0]  r_lat;
  logic [7:0]        r_pass, r_loops;
  logic [1:0]        r_mode;
  logic              r_err_flag;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_first_idx;
  logic [DATA_W-1:0] r_first_data;

  logic              w_accept, w_abort, w_chk_vld;
  logic [7:0]        w_pass_nxt;
  logic [ADDR_W-1:0] w_chk_idx;
  logic [DATA_W-1:0] w_wr_pat, w_chk_pat;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_init_meta <= 1'b0;
      r_init_s    <= 1'b0;
    end else begin
      r_init_meta <= sdram_init_done;
      r_init_s    <= r_init_meta;
    end
  end

  assign w_accept   = (r_state == ST_IDLE) && start && r_init_s;
  assign w_abort    = (r_state != ST_IDLE) && !r_init_s;
  assign w_pass_nxt = r_pass + 8'd1;

  // READ spends its first cycle with r_idx == 0 so wr_en and rd_en never abut.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_lat   <= '0;
      r_pass  <= '0;
      r_loops <= '0;
      r_mode  <= '0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_state <= ST_WRITE;
          r_idx   <= ADDR_W'(1);
          r_pass  <= '0;
          r_mode  <= mode;
          r_loops <= loops;
        end
        ST_WRITE: if (r_idx == C_LAST) begin
          r_state <= ST_READ;
          r_idx   <= '0;
        end else r_idx <= r_idx + ADDR_W'(1);
        ST_READ: if (r_idx == C_LAST) begin
          r_state <= ST_DRAIN;
          r_idx   <= '0;
          r_lat   <= '0;
        end else r_idx <= r_idx + ADDR_W'(1);
        ST_DRAIN: if (r_lat == C_LAT_END) begin
          r_pass <= w_pass_nxt;
          if (r_loops == 8'd0 || w_pass_nxt < r_loops) begin
            r_state <= ST_WRITE;
            r_idx   <= ADDR_W'(1);
          end else r_state <= ST_DONE;
        end else r_lat <= r_lat + LAT_W'(1);
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sdram_pattern_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_gen (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .flush   (w_abort),
    .mode    (r_mode),
    .wr_idx  (r_idx),
    .rd_vld  (rd_en),
    .rd_idx  (r_idx),
    .wr_pat  (w_wr_pat),
    .chk_vld (w_chk_vld),
    .chk_idx (w_chk_idx),
    .chk_pat (w_chk_pat)
  );

  always_ff @(posedge clk_50m) begin
    if (!rst_n || w_accept) begin
      r_err_flag   <= 1'b0;
      r_err_cnt    <= '0;
      r_first_idx  <= '0;
      r_first_data <= '0;
    end else if (w_chk_vld && (rd_data != w_chk_pat)) begin
      r_err_flag <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (!r_err_flag) begin
        r_first_idx  <= w_chk_idx;
        r_first_data <= rd_data;
      end
    end
  end

  assign wr_en          = (r_state == ST_WRITE);
  assign rd_en          = (r_state == ST_READ) && (r_idx != '0);
  assign wr_data        = wr_en ? w_wr_pat : '0;
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign error_flag     = r_err_flag;
  assign err_cnt        = r_err_cnt;
  assign first_err_idx  = r_first_idx;
  assign first_err_data = r_first_data;

endmodule
`default_nettype wire

// File: tb/tb_sdram_pattern_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdram_pattern_tester : directed bench with a RD_LAT=2 loopback memory
// Revision                : 1.0
// ---------------------------------------------------------------------------
module tb_sdram_pattern_tester;

  localparam int DATA_W    = 16;
  localparam int DATA_LENG = 20;
  localparam int RD_LAT    = 2;
  localparam int CNT_W     = 4;
  localparam int ADDR_W    = $clog2(DATA_LENG + 1);

  logic              clk_50m = 1'b0;
  logic              rst_n = 1'b0;
  logic              sdram_init_done = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [7:0]        loops = 8'd0;
  logic              wr_en, rd_en, busy, done, error_flag;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_err_idx;
  logic [DATA_W-1:0] first_err_data;

  int n_pass = 0, n_total = 0;
  int done_seen = 0, overlap_seen = 0;

  always #10 clk_50m = ~clk_50m;

  sdram_pattern_tester #(
    .DATA_W    (DATA_W),
    .DATA_LENG (DATA_LENG),
    .RD_LAT    (RD_LAT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_50m         (clk_50m),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .start           (start),
    .mode            (mode),
    .loops           (loops),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .busy            (busy),
    .done            (done),
    .error_flag      (error_flag),
    .err_cnt         (err_cnt),
    .first_err_idx   (first_err_idx),
    .first_err_data  (first_err_data)
  );

  // Loopback memory: read word appears two cycles after its rd_en cycle.
  logic [DATA_W-1:0] mem [1:DATA_LENG];
  int                wptr = 1, rptr = 1;
  int                corrupt_idx = 0;
  bit                corrupt_all = 1'b0;
  logic [DATA_W-1:0] corrupt_val = '0;
  logic [DATA_W-1:0] pipe0, pipe1;

  always @(posedge clk_50m) begin
    if (!busy) begin
      wptr <= 1;
      rptr <= 1;
    end else begin
      if (wr_en) begin
        mem[wptr] <= wr_data;
        wptr <= (wptr == DATA_LENG) ? 1 : wptr + 1;
      end
      if (rd_en) rptr <= (rptr == DATA_LENG) ? 1 : rptr + 1;
    end
    pipe0 <= !rd_en ? 16'hDEAD :
             (corrupt_all || rptr == corrupt_idx) ? corrupt_val : mem[rptr];
    pipe1 <= pipe0;
  end
  assign rd_data = pipe1;

  always @(negedge clk_50m) begin
    if (wr_en && rd_en) overlap_seen++;
    if (done) done_seen++;
  end

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [7:0] l);
    mode  = m;
    loops = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, d0;

    ticks(3);
    chk("rst_ctl", {wr_en, rd_en, busy, done, error_flag}, 5'b0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_idx", first_err_idx, 0);
    chk("rst_first_data", first_err_data, 0);

    rst_n = 1'b1;
    tick();
    start_run(2'd0, 8'd1);
    chk("start_no_init", busy, 1'b0);
    sdram_init_done = 1'b1;
    ticks(3);

    // Run 1: incrementing pattern, clean loopback
    start_run(2'd0, 8'd1);
    chk("r1_wr_en_c1", wr_en, 1'b1);
    chk("r1_wr_data_c1", wr_data, 16'h0001);
    ticks(19);
    chk("r1_wr_data_c20", wr_data, 16'h0014);
    tick();
    chk("r1_gap", {wr_en, rd_en}, 2'b00);
    tick();
    chk("r1_rd_en_c22", rd_en, 1'b1);
    wait_done(22, cyc);
    chk("r1_done", done, 1'b1);
    chk("r1_done_cycle", cyc, 45);
    tick();
    chk("r1_done_pulse", {done, busy}, 2'b00);
    chk("r1_err_flag", error_flag, 1'b0);
    chk("r1_err_cnt", err_cnt, 0);

    // Run 2: word 5 corrupted
    corrupt_idx = 5;
    corrupt_val = 16'h00FF;
    start_run(2'd0, 8'd1);
    wait_done(1, cyc);
    chk("r2_done_cycle", cyc, 45);
    chk("r2_err_flag", error_flag, 1'b1);
    chk("r2_err_cnt", err_cnt, 1);
    chk("r2_first_idx", first_err_idx, 5);
    chk("r2_first_data", first_err_data, 16'h00FF);
    corrupt_idx = 0;
    tick();

    // Run 3: walking one, every word corrupted, counter saturates
    corrupt_all = 1'b1;
    corrupt_val = 16'h1234;
    start_run(2'd2, 8'd1);
    chk("r3_cleared", {error_flag, 4'(err_cnt)}, 5'b0);
    chk("r3_wr_c1", wr_data, 16'h0001);
    ticks(15);
    chk("r3_wr_c16", wr_data, 16'h8000);
    tick();
    chk("r3_wr_c17", wr_data, 16'h0001);
    tick();
    chk("r3_wr_c18", wr_data, 16'h0002);
    wait_done(18, cyc);
    chk("r3_done_cycle", cyc, 45);
    chk("r3_err_cnt_sat", err_cnt, 15);
    chk("r3_first_idx", first_err_idx, 1);
    chk("r3_first_data", first_err_data, 16'h1234);
    corrupt_all = 1'b0;
    tick();

    // Run 4: checkerboard, three passes, start mid-run ignored
    d0 = done_seen;
    start_run(2'd3, 8'd3);
    chk("r4_wr_c1", wr_data, 16'hAAAA);
    tick();
    chk("r4_wr_c2", wr_data, 16'h5555);
    start_run(2'd0, 8'd1);
    chk("r4_wr_c3_mode_kept", wr_data, 16'hAAAA);
    wait_done(3, cyc);
    chk("r4_done_cycle", cyc, 133);
    chk("r4_err_flag", error_flag, 1'b0);
    tick();
    chk("r4_one_done", done_seen - d0, 1);
    chk("r4_idle", busy, 1'b0);

    // Run 5: inverse pattern, loops=0, abort in READ after one error
    corrupt_idx = 3;
    corrupt_val = 16'h0000;
    start_run(2'd1, 8'd0);
    chk("r5_wr_c1", wr_data, 16'hFFFE);
    ticks(29);
    chk("r5_rd_en_c30", rd_en, 1'b1);
    d0 = done_seen;
    sdram_init_done = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk("r5_abort_in_time", (n >= 1 && n <= 3), 1'b1);
    chk("r5_abort_ctl", {busy, rd_en, wr_en}, 3'b000);
    chk("r5_err_kept", err_cnt, 1);
    chk("r5_first_idx_kept", first_err_idx, 3);
    chk("r5_no_done", done_seen - d0, 0);
    corrupt_idx = 0;
    sdram_init_done = 1'b1;
    ticks(3);
    start_run(2'd0, 8'd1);
    chk("r5_restart_clear", {error_flag, 4'(err_cnt)}, 5'b0);

    // Run 6: reset pulse during WRITE
    ticks(4);
    chk("r6_wr_en_c5", wr_en, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("r6_rst_ctl", {wr_en, rd_en, busy, done, error_flag}, 5'b0);
    chk("r6_rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    ticks(2);
    chk("r6_stays_idle", busy, 1'b0);

    chk("no_wr_rd_overlap", overlap_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
Parametrised successor of the single-pattern SDRAM self-test. Writes a DATA_LENG-word pattern into the SDRAM write-port FIFO, then reads it back and checks it with a fixed, known read latency. Supports four patterns, a repeat count, run control by start/done, and error statistics. Sits between the SDRAM controller FIFO ports and board status logic (LEDs/debug UART).

Parameters:
DATA_W, 16, width of the wr_data and rd_data words
DATA_LENG, 2048, number of words per write pass and per read pass (>=2)
RD_LAT, 2, cycles from a rd_en cycle to its valid rd_data word (>=1)
CNT_W, 16, width of the saturating error counter

Ports:
clk_50m  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
sdram_init_done  in  1  controller init complete; asynchronous, double-flop synchronised inside
start  in  1  one-cycle run request
mode  in  2  pattern select, sampled on accepted start
loops  in  8  passes to run, sampled on accepted start; 0 = run until init drops
wr_en  out  1  write FIFO enable
wr_data  out  DATA_W  write word
rd_en  out  1  read FIFO enable
rd_data  in  DATA_W  read word, valid RD_LAT cycles after rd_en
busy  out  1  high from accepted start until DONE/abort
done  out  1  one-cycle pulse at normal completion
error_flag  out  1  sticky, set on any mismatch
err_cnt  out  CNT_W  mismatch count, saturates at all-ones
first_err_idx  out  ADDR_W  index (1..DATA_LENG) of first mismatch
first_err_data  out  DATA_W  rd_data captured at first mismatch

Behaviour:
- ADDR_W = clog2(DATA_LENG+1) is derived. The index counter i runs 1..DATA_LENG.
- Pattern pat(i, mode) is a pure function of the index:
  - mode 0: i truncated or zero-extended to DATA_W.
  - mode 1: bitwise inverse of mode 0.
  - mode 2: walking one, bit ((i-1) mod DATA_W) set.
  - mode 3: checkerboard, odd i = 0xAA.. and even i = 0x55.., sized to DATA_W.
- Reset values: all outputs 0, state IDLE, synchroniser flops 0.
- FSM states and transitions:
  - IDLE -> WRITE on start && init_s. Otherwise start is ignored. On entry to WRITE, clear error_flag, err_cnt, first_err_*.
  - WRITE: wr_en=1 and wr_data=pat(i) for exactly DATA_LENG consecutive cycles (i = 1..DATA_LENG). Then -> READ.
  - READ: rd_en=1 for exactly DATA_LENG consecutive cycles. Then -> DRAIN.
  - DRAIN: wait RD_LAT cycles for the last compare. Then pass_cnt+1. If loops==0 or pass_cnt<loops -> WRITE, otherwise -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Compare path:
  - An RD_LAT-deep shift register carries rd_en and i alongside the read.
  - When the delayed valid is high and rd_data != pat(delayed i, mode): set error_flag and increment err_cnt (hold at max).
  - If this is the first error since start, capture first_err_idx and first_err_data.
  - No cycle of read data is discarded; the valid pipeline handles latency.
- busy=1 in WRITE, READ, DRAIN and DONE.
- wr_en and rd_en are never high in the same cycle. Between WRITE and READ there is exactly one cycle with both low (first cycle of READ state is the registered transition).
- Abort: init_s falling in any non-IDLE state -> IDLE next cycle.
  - wr_en, rd_en and busy drop, and the compare pipeline is flushed.
  - No done pulse; error statistics are retained.
- start while busy: ignored.
- rst_n low mid-run: all state and outputs return to reset values on the next edge.
- Latency: first wr_en occurs 1 cycle after accepted start. One pass takes 2*DATA_LENG + RD_LAT + 2 cycles.

Decomposition:
- Shared package sdram_test_pkg holds:
  - mode encodings PAT_INC, PAT_INV, PAT_WALK, PAT_CHK;
  - state encoding (IDLE, WRITE, READ, DRAIN, DONE);
  - function pat_gen(idx, mode).
- One natural sub-module, sdram_pattern_gen: combinational pattern function plus the registered RD_LAT valid/index delay line. It is instantiated once, with the generator on the write path and the checker reusing pat_gen.

Test Plan:
- Reset, init_done=1, start, mode=0, loops=1, DATA_LENG=8, RD_LAT=2, ideal loopback model -> wr_data 1..8, then rd_en 8 cycles, done one pulse at cycle 2*8+2+2+1 after start, error_flag=0, err_cnt=0.
- Same setup, model corrupts word 5 to 0x00FF -> error_flag=1, err_cnt=1, first_err_idx=5, first_err_data=0x00FF, done still pulses.
- mode=2, DATA_W=16, DATA_LENG=20 -> wr_data 0x0001,0x0002,..,0x8000,0x0001..0x0008; model corrupts every word -> err_cnt=20, first_err_idx=1.
- loops=3, mode=3 -> three WRITE/READ passes with 0xAAAA/0x5555 alternation, exactly one done pulse; a start issued mid-run is ignored.
- Drop sdram_init_done during READ of loops=0 run -> busy=0 within sync delay + 1 cycle, rd_en=0, no done; restart then clears err_cnt.
- rst_n low for one cycle during WRITE -> all outputs 0 next edge; CNT_W=4 with 20 errors -> err_cnt saturates at 15.
